// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle IEEE-754 divider with RNE rounding, subnormals and canonical qNaN.
// Define FP_DIV_FLAGS_EN to add the 5-bit {invalid, divzero, overflow, underflow, inexact} output.
module fp_div_seq #(
  parameter int EXP_W          = 5,
  parameter int MAN_W          = 10,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] y
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]           flags
`endif
);

  localparam int W    = EXP_W + MAN_W + 1;
  localparam int EW   = EXP_W + 4;
  localparam int QB   = MAN_W + 5;
  localparam int ITER = (QB + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int QW   = ITER * BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int LZW  = $clog2(MAN_W + 2);

  localparam logic [EW-1:0]  ONE_E    = EW'(1);
  localparam logic [EW-1:0]  BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]  EMAX_E   = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0]  QB_E     = EW'(QB);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(ITER - 1);
  localparam logic [LZW-1:0] ONE_L    = LZW'(1);
  localparam logic [W-1:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t              state;
  logic [MAN_W+1:0]    rem_q;
  logic [MAN_W:0]      mant_b_q;
  logic [EW-1:0]       exp_q;
  logic                sign_q;
  logic [QW-1:0]       quo_q;
  logic [CW-1:0]       cnt_q;

  logic                sa, sb;
  logic [EXP_W-1:0]    ea, eb, ea_adj, eb_adj;
  logic [MAN_W-1:0]    fa, fb;
  logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MAN_W:0]      mant_a_raw, mant_b_raw, mant_a_n, mant_b_n;
  logic [LZW-1:0]      sha, shb;
  logic [EW-1:0]       new_exp;
  logic                spec_hit, spec_invalid;
  logic [W-1:0]        spec_y;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  function automatic logic [LZW-1:0] lead_zeros(input logic [MAN_W:0] m);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = MAN_W; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + ONE_L;
      end
    end
    return n;
  endfunction

  // Operand classification, leading-one normalisation and the unrounded exponent.
  always_comb begin
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);

    mant_a_raw = {|ea, fa};
    mant_b_raw = {|eb, fb};
    sha        = lead_zeros(mant_a_raw);
    shb        = lead_zeros(mant_b_raw);
    mant_a_n   = mant_a_raw << sha;
    mant_b_n   = mant_b_raw << shb;
    ea_adj     = ea | {{(EXP_W-1){1'b0}}, ~(|ea)};
    eb_adj     = eb | {{(EXP_W-1){1'b0}}, ~(|eb)};
    new_exp    = EW'(ea_adj) - EW'(eb_adj) + BIAS_E + EW'(shb) - EW'(sha);

    spec_invalid = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
    spec_hit     = 1'b1;
    spec_y       = {sa ^ sb, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    if (spec_invalid)
      spec_y = QNAN;
    else if (a_inf | b_zero)
      spec_y = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf | a_zero)
      spec_y = {sa ^ sb, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else
      spec_hit = 1'b0;
  end

  logic [MAN_W+1:0] div_rem;
  logic [QW-1:0]    div_quo;

  // Restoring division; the remainder always stays below twice the divisor.
  always_comb begin
    div_rem = rem_q;
    div_quo = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_rem >= {1'b0, mant_b_q}) begin
        div_rem = div_rem - {1'b0, mant_b_q};
        div_quo = {div_quo[QW-2:0], 1'b1};
      end else begin
        div_quo = {div_quo[QW-2:0], 1'b0};
      end
      div_rem = {div_rem[MAN_W:0], 1'b0};
    end
  end

  logic [QB-1:0]    sig;
  logic             sticky, tiny, g, r, s, inc, ovf;
  logic [EW-1:0]    e_n, e_r, sh;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     rnd_y;

  // Normalise, denormalise when tiny, then round-to-nearest-even and pack.
  always_comb begin
    sig    = quo_q[QW-1 -: QB];
    sticky = (rem_q != '0);
    for (int i = 0; i < QW - QB; i++) sticky = sticky | quo_q[i];
    e_n = exp_q;
    if (!sig[QB-1]) begin
      sig = {sig[QB-2:0], 1'b0};
      e_n = exp_q - ONE_E;
    end
    tiny = e_n[EW-1] | (e_n == '0);
    sh   = ONE_E - e_n;
    if (tiny) begin
      if (sh >= QB_E) begin
        sticky = sticky | (|sig);
        sig    = '0;
      end else begin
        sticky = sticky | (|(sig & ~({QB{1'b1}} << sh)));
        sig    = sig >> sh;
      end
    end

    mant   = sig[QB-1 -: MAN_W+1];
    g      = sig[QB-2-MAN_W];
    r      = sig[QB-3-MAN_W];
    s      = sticky | (|sig[QB-4-MAN_W:0]);
    inc    = g & (r | s | mant[0]);
    mant_r = {1'b0, mant} + (MAN_W+2)'(inc);

    e_r  = e_n;
    frac = mant_r[MAN_W-1:0];
    if (tiny) begin
      e_r = mant_r[MAN_W] ? ONE_E : '0;
    end else if (mant_r[MAN_W+1]) begin
      e_r  = e_n + ONE_E;
      frac = mant_r[MAN_W:1];
    end
    ovf   = !tiny && (e_r >= EMAX_E);
    rnd_y = ovf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                : {sign_q, e_r[EXP_W-1:0], frac};
  end

`ifdef FP_DIV_FLAGS_EN
  logic [4:0] spec_flags, rnd_flags;
  always_comb begin
    spec_flags = {spec_invalid, b_zero & ~a_zero & ~a_inf & ~a_nan, 3'b000};
    rnd_flags  = {2'b00, ovf, tiny & (g | r | s), g | r | s | ovf};
  end
`endif

  // Control FSM; y, out_valid and in_ready are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      rem_q     <= '0;
      mant_b_q  <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      quo_q     <= '0;
      cnt_q     <= '0;
`ifdef FP_DIV_FLAGS_EN
      flags     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_q   <= sa ^ sb;
            if (spec_hit) begin
              y         <= spec_y;
              out_valid <= 1'b1;
              state     <= DONE;
`ifdef FP_DIV_FLAGS_EN
              flags     <= spec_flags;
`endif
            end else begin
              rem_q    <= {1'b0, mant_a_n};
              mant_b_q <= mant_b_n;
              exp_q    <= new_exp;
              quo_q    <= '0;
              cnt_q    <= '0;
              state    <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= div_rem;
          quo_q <= div_quo;
          cnt_q <= cnt_q + ONE_C;
          if (cnt_q == LAST_CNT) state <= ROUND;
        end
        ROUND: begin
          y         <= rnd_y;
          out_valid <= 1'b1;
          state     <= DONE;
`ifdef FP_DIV_FLAGS_EN
          flags     <= rnd_flags;
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: table-driven scoreboard bench for fp_div_seq (fp16 BPC=1 and fp32 BPC=2 instances).
// Flag checks are compiled in when FP_DIV_FLAGS_EN is defined.
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, y16;
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, y32;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags16, flags32;
`endif

  fp_div_seq #(.EXP_W(5), .MAN_W(10), .BITS_PER_CYCLE(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .y(y16)
`ifdef FP_DIV_FLAGS_EN
    , .flags(flags16)
`endif
  );

  fp_div_seq #(.EXP_W(8), .MAN_W(23), .BITS_PER_CYCLE(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32), .y(y32)
`ifdef FP_DIV_FLAGS_EN
    , .flags(flags32)
`endif
  );

  typedef struct {
    bit          is32;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  flags;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic get_in_ready(input bit is32);
    return is32 ? in_ready32 : in_ready16;
  endfunction

  function automatic logic get_out_valid(input bit is32);
    return is32 ? out_valid32 : out_valid16;
  endfunction

  function automatic logic [31:0] get_y(input bit is32);
    return is32 ? y32 : {16'h0000, y16};
  endfunction

`ifdef FP_DIV_FLAGS_EN
  function automatic logic [4:0] get_flags(input bit is32);
    return is32 ? flags32 : flags16;
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drives one operation, queues its expected result and measures edges until out_valid.
  task automatic applyStimulus(input bit is32, input logic [31:0] ta, input logic [31:0] tb,
                               input logic [31:0] ey, input logic [4:0] ef, input int elat,
                               input string name);
    int lat;
    exp_t e;
    e.y     = ey;
    e.flags = ef;
    sb_q.push_back(e);
    check({name, " in_ready"}, 32'(get_in_ready(is32)), 32'd1);
    if (is32) begin
      a32 = ta; b32 = tb; in_valid32 = 1'b1;
    end else begin
      a16 = ta[15:0]; b16 = tb[15:0]; in_valid16 = 1'b1;
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    in_valid32 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    a32 = $urandom;
    b32 = $urandom;
    lat = 1;
    while (!get_out_valid(is32) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(elat));
  endtask

  // Pops the scoreboard, compares the result and completes the output handshake.
  task automatic checkOutput(input bit is32, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: scoreboard empty, got %h, expected an entry", name, get_y(is32));
      return;
    end
    e = sb_q.pop_front();
    check({name, " y"}, get_y(is32), e.y);
`ifdef FP_DIV_FLAGS_EN
    check({name, " flags"}, 32'(get_flags(is32)), 32'(e.flags));
`endif
    if (is32) out_ready32 = 1'b1;
    else      out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    out_ready32 = 1'b0;
    check({name, " out_valid drop"}, 32'(get_out_valid(is32)), 32'd0);
    check({name, " in_ready back"}, 32'(get_in_ready(is32)), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready16", 32'(in_ready16), 32'd1);
    check("reset out_valid16", 32'(out_valid16), 32'd0);
    check("reset y16", 32'(y16), 32'd0);
    check("reset in_ready32", 32'(in_ready32), 32'd1);
    check("reset out_valid32", 32'(out_valid32), 32'd0);
    check("reset y32", y32, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // flags order: {invalid, divzero, overflow, underflow, inexact}
    vecs.push_back('{0, 32'h3C00, 32'h4200, 32'h3555, 5'b00001, 17});
    vecs.push_back('{0, 32'h4600, 32'h4000, 32'h4200, 5'b00000, 17});
    vecs.push_back('{0, 32'h3C00, 32'h0000, 32'h7C00, 5'b01000, 1});
    vecs.push_back('{0, 32'h0000, 32'h0000, 32'h7E00, 5'b10000, 1});
    vecs.push_back('{0, 32'hFC00, 32'h3C00, 32'hFC00, 5'b00000, 1});
    vecs.push_back('{0, 32'h7BFF, 32'h3800, 32'h7C00, 5'b00101, 17});
    vecs.push_back('{0, 32'h0400, 32'h4000, 32'h0200, 5'b00000, 17});
    vecs.push_back('{0, 32'h0001, 32'h4000, 32'h0000, 5'b00011, 17});
    vecs.push_back('{0, 32'h7E01, 32'h3C00, 32'h7E00, 5'b10000, 1});
    vecs.push_back('{0, 32'h7C00, 32'hFC00, 32'h7E00, 5'b10000, 1});
    vecs.push_back('{0, 32'hBC00, 32'h7C00, 32'h8000, 5'b00000, 1});
    vecs.push_back('{0, 32'h8000, 32'h3C00, 32'h8000, 5'b00000, 1});
    vecs.push_back('{0, 32'hC500, 32'h4100, 32'hC000, 5'b00000, 17});
    vecs.push_back('{0, 32'h0200, 32'h0400, 32'h3800, 5'b00000, 17});
    vecs.push_back('{0, 32'h7BFF, 32'h3BFF, 32'h7C00, 5'b00101, 17});
    vecs.push_back('{0, 32'h07FF, 32'h4000, 32'h0400, 5'b00011, 17});
    vecs.push_back('{0, 32'h3C00, 32'h8001, 32'hFC00, 5'b00101, 17});
    vecs.push_back('{0, 32'h8001, 32'h3C00, 32'h8001, 5'b00000, 17});
    vecs.push_back('{1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 16});
    vecs.push_back('{1, 32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 16});
    vecs.push_back('{1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1});
    vecs.push_back('{1, 32'h00000000, 32'h7FC00001, 32'h7FC00000, 5'b10000, 1});

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d %h/%h", i, vecs[i].a, vecs[i].b);
      applyStimulus(vecs[i].is32, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].flags, vecs[i].lat, nm);
      checkOutput(vecs[i].is32, nm);
    end

    // Consumer stall: result must stay put while out_ready is low.
    applyStimulus(0, 32'h4600, 32'h4000, 32'h4200, 5'b00000, 17, "stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d y", i), 32'(y16), 32'h4200);
      check($sformatf("stall%0d out_valid", i), 32'(out_valid16), 32'd1);
      check($sformatf("stall%0d in_ready", i), 32'(in_ready16), 32'd0);
    end
    checkOutput(0, "stall");

    // Reset in the middle of DIVIDE discards the operation.
    a16 = 16'h4600; b16 = 16'h4000; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midop busy in_ready", 32'(in_ready16), 32'd0);
    check("midop busy out_valid", 32'(out_valid16), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop rst out_valid", 32'(out_valid16), 32'd0);
    check("midop rst in_ready", 32'(in_ready16), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid16) seen = 1;
    end
    check("midop no stray output", 32'(seen), 32'd0);
    applyStimulus(0, 32'h4600, 32'h4000, 32'h4200, 5'b00000, 17, "after reset");
    checkOutput(0, "after reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
